// File: rtl/core_link_pkg.sv
// Shared constants for the inter-core link FIFO.
// Status and control bit positions used by producer and consumer ports.
package core_link_pkg;

  localparam int LINK_DATA_W = 14;
  localparam int ST_W        = 14;

  localparam int ST_ECHO     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_PEND     = 2;
  localparam int ST_UFLOW    = 2;
  localparam int ST_CNT_LSB  = 3;
  localparam int ST_CNT_MSB  = 9;
  localparam int ST_STAT_LSB = 10;

  localparam int CTL_TOGGLE  = 0;
  localparam int CTL_CLR     = 1;

endpackage

// File: rtl/core_link_ram.sv
// Storage array for the link FIFO.
// Synchronous write port, asynchronous read port.
module core_link_ram
  import core_link_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = LINK_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/core_link_fifo.sv
// Toggle-handshake message FIFO between two cores' port pairs.
// Define CORE_LINK_STATS_EN to add the stall counter in tx_status[13:10].
module core_link_fifo
  import core_link_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = LINK_DATA_W,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              Clock_pin,
  input  logic              Reset_pin,
  input  logic [ST_W-1:0]   tx_ctrl,
  input  logic [DATA_W-1:0] tx_data,
  output logic [ST_W-1:0]   tx_status,
  input  logic [ST_W-1:0]   rx_ctrl,
  output logic [DATA_W-1:0] rx_data,
  output logic [ST_W-1:0]   rx_status
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_echo_q, tx_echo_d;
  logic              rx_echo_q, rx_echo_d;
  logic              uflow_q, uflow_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              push_req, pop_req;
  logic              push_ok, pop_ok;
  logic              full, empty;
  logic [3:0]        stat;
  logic [6:0]        free, occ;
  logic              unused;

  core_link_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (Clock_pin),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (tx_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    push_req  = tx_ctrl[CTL_TOGGLE] != tx_echo_q;
    pop_req   = rx_ctrl[CTL_TOGGLE] != rx_echo_q;
    full      = cnt_q == CNT_W'(DEPTH);
    empty     = cnt_q == '0;
    pop_ok    = pop_req && !empty;
    push_ok   = push_req && (!full || pop_ok);
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    tx_echo_d = push_ok ? tx_ctrl[CTL_TOGGLE] : tx_echo_q;
    rx_echo_d = rx_ctrl[CTL_TOGGLE];
    pend_d    = push_req && !push_ok;
    cnt_d     = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    uflow_d = uflow_q;
    if (rx_ctrl[CTL_CLR]) uflow_d = 1'b0;
    else if (pop_req && empty) uflow_d = 1'b1;
    // The new head is the word being written when the FIFO was empty
    rdata_d = '0;
    if (cnt_d != '0)
      rdata_d = (push_ok && rd_ptr_d == wr_ptr_q) ? tx_data : ram_rdata;
  end

  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tx_echo_q <= 1'b0;
      rx_echo_q <= 1'b0;
      uflow_q   <= 1'b0;
      pend_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      tx_echo_q <= tx_echo_d;
      rx_echo_q <= rx_echo_d;
      uflow_q   <= uflow_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef CORE_LINK_STATS_EN
  logic [3:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (tx_ctrl[CTL_CLR]) stat_d = '0;
    else if (pend_d && stat_q != 4'hF) stat_d = stat_q + 4'd1;
  end

  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) stat_q <= '0;
    else stat_q <= stat_d;
  end

  assign stat   = stat_q;
  assign unused = ^{tx_ctrl[ST_W-1:2], rx_ctrl[ST_W-1:2]};
`else
  assign stat   = 4'b0;
  assign unused = ^{tx_ctrl[ST_W-1:1], rx_ctrl[ST_W-1:2]};
`endif

  assign free = 7'(DEPTH) - 7'(cnt_q);
  assign occ  = 7'(cnt_q);

  assign tx_status = {stat, free, pend_q, full, tx_echo_q};
  assign rx_status = {4'b0, occ, uflow_q, !empty, rx_echo_q};
  assign rx_data   = rdata_q;

endmodule

// File: doc/core_link_fifo.md
Name: core_link_fifo

Overview:
- Unidirectional inter-core message channel inserted between one core's ack/data output-port pair and another core's ack/data input-port pair.
- Replaces the direct wire-through of producer OutN/OutN+1 to consumer InN/InN+1 in multicore builds.
- Buffers 14-bit words in a FIFO and uses toggle handshakes, so software on either core never clears flags.
- One instance per direction per core pair.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64.
DATA_W, 14, word width; matches the core peripheral port width.
CNT_W, $clog2(DEPTH)+1, localparam; occupancy counter width.

Ports:
Clock_pin  in  1  system clock; all logic on the rising edge.
Reset_pin  in  1  synchronous, active-high reset.
tx_ctrl  in  14  from producer OutN; bit0 = send toggle; other bits ignored.
tx_data  in  14  from producer OutN+1; word to send; held until echoed.
tx_status  out  14  to producer InN: [0] send echo, [1] full, [2] pending, [9:3] free slots, [13:10] stats (see Optional Feature).
rx_ctrl  in  14  from consumer OutN: [0] pop toggle, [1] underflow clear (level); others ignored.
rx_data  out  14  to consumer InN+1; FIFO head word; 0 when empty.
rx_status  out  14  to consumer InN: [0] pop echo, [1] non-empty, [2] underflow sticky, [9:3] occupancy, [13:10] 0.

Behaviour:
- Reset (Reset_pin high at an edge) sets:
  - pointers, count, tx echo, rx echo, underflow and stats to 0;
  - rx_data = 0; tx_status = {4'b0, free=DEPTH, 3'b000}; rx_status = 0.
- Reset mid-transfer discards all contents. Echoes return to 0, so an endpoint whose ctrl bit0 = 1 sees an immediate new request after reset.
- Push request is defined as tx_ctrl[0] != tx_echo.
  - At an edge with a request and space (count < DEPTH, or count == DEPTH with a pop accepted at the same edge), tx_data is written at wr_ptr, wr_ptr increments (wrapping at DEPTH), and tx_echo <= tx_ctrl[0].
  - With no space, the request stays pending and tx_status[2] = 1. No data is lost.
  - Producer withdraws a pending send by toggling bit0 back; the request disappears with no write.
- Pop request is defined as rx_ctrl[0] != rx_echo.
  - At an edge with a request and count > 0, rd_ptr increments (wrap) and rx_echo <= rx_ctrl[0].
  - At an edge with a request and count == 0, rx_echo is still updated, underflow is set, and the FIFO is unchanged.
- Underflow clear: underflow <= 0 while rx_ctrl[1] = 1. Clear beats a simultaneous set.
- Count update: +1 push only, -1 pop only, unchanged when both or neither.
- Simultaneous push and pop on empty: underflow is set and the word is still written (no bypass); count becomes 1.
- All outputs are registered. A request sampled at edge k is reflected in echo, count, rx_data and flags after edge k (1-cycle latency). A pushed word is visible on rx_data after the pushing edge.
- rx_data always equals mem[rd_ptr] when non-empty.
- Full flag = (count == DEPTH). Free slots = DEPTH - count.
- Software contract:
  - Producer writes tx_data, toggles tx_ctrl[0], then polls tx_status[0] for a match before the next send.
  - Consumer reads rx_data when rx_status[1] = 1, toggles rx_ctrl[0], then waits for rx_status[0] to match.

Optional Feature:
CORE_LINK_STATS_EN
- Defined: tx_status[13:10] is a 4-bit saturating count (stops at 15) of edges where a push request was stalled by full. It clears on reset or at any edge with tx_ctrl[1] = 1.
- Undefined: tx_status[13:10] is constant 0, tx_ctrl[1] is ignored, and no counter logic is synthesized.

Decomposition:
- Package core_link_pkg holds:
  - DATA_W default;
  - status bit index constants (ST_ECHO=0, ST_FULL=1, ST_PEND=2, ST_UFLOW=2, ST_CNT_LSB=3, ST_CNT_MSB=9, ST_STAT_LSB=10);
  - ctrl bit constants (CTL_TOGGLE=0, CTL_CLR=1).
- Sub-module core_link_ram: DEPTH x DATA_W register array, synchronous write, asynchronous read. core_link_fifo owns pointers, count, handshake and status.

Test Plan:
- Reset, then one send (tx_data=14'h0123, tx_ctrl[0] 0->1) -> after 1 edge: tx_status[0]=1, rx_status[1]=1, occupancy=1, rx_data=14'h0123.
- Push 8 words 1..8 with DEPTH=8, then a 9th (value 9) -> full=1, pending=1, echo unchanged; one consumer pop -> next edge writes 9, echo matches, occupancy 8, rx_data=2.
- Drain all 8 words one pop at a time -> rx_data sequence 2..9 (after the prior pop consumed 1), then empty, rx_data=0, underflow=0.
- Pop toggle on empty -> rx_status[0] matches, underflow=1, occupancy 0; rx_ctrl[1]=1 for one edge -> underflow=0.
- Full FIFO with simultaneous push (value 14'h3FFF) and pop at the same edge -> occupancy stays 8, head advances, 14'h3FFF lands last; with CORE_LINK_STATS_EN, 20 stalled edges -> tx_status[13:10]=15.
- Reset asserted while occupancy = 5 and a push is pending -> next edge: all status 0 except free=DEPTH, rx_data=0.
